// File: rtl/fc_mac_engine.sv
// fc_mac_engine: serial fixed-point dot product plus bias for one neuron.
// Waits for both DMA buffers, accumulates in[k]*w[k], rounds, saturates, ReLU.
module fc_mac_engine #(
  parameter int BUFFER_SIZE       = 120,
  parameter int WORD_SIZE         = 16,
  parameter int FRAC_BITS         = 8,
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int GUARD_BITS        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [MEM_ADDRESS_WIDTH-1:0] i_count,
  input  logic [WORD_SIZE-1:0]         i_bias,
  input  logic                         i_relu,
  input  logic [0:BUFFER_SIZE-1][WORD_SIZE-1:0] i_in_buffer,
  input  logic                         i_in_ready,
  input  logic [0:BUFFER_SIZE-1][WORD_SIZE-1:0] i_w_buffer,
  input  logic                         i_w_ready,
  output logic                         o_busy,
  output logic [WORD_SIZE-1:0]         o_result,
  output logic                         o_valid
);

  localparam int PW = 2 * WORD_SIZE;
  localparam int AW = PW + GUARD_BITS;
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  localparam logic signed [AW:0] SAT_HI =
    {{(AW + 2 - WORD_SIZE){1'b0}},
     {(WORD_SIZE - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_LO =
    {{(AW + 2 - WORD_SIZE){1'b1}},
     {(WORD_SIZE - 1){1'b0}}};
  localparam logic [AW:0] HALF_LSB =
    (AW + 1)'(1) << (FRAC_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_MAC,
    S_RESULT
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          idx_q;
  logic [WORD_SIZE-1:0]   bias_q;
  logic                   relu_q;
  logic                   in_flag_q;
  logic                   w_flag_q;
  logic signed [AW-1:0]   acc_q;
  logic [WORD_SIZE-1:0]   o_result_q;
  logic                   o_valid_q;

  logic [CW-1:0]          cnt_d;
  logic                   in_flag_d;
  logic                   w_flag_d;
  logic                   both_rdy;
  logic                   last_term;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   mac_d;
  logic signed [AW-1:0]   acc_init_d;
  logic signed [AW:0]     rnd_d;
  logic signed [AW:0]     shr_d;
  logic [WORD_SIZE-1:0]   sat_d;
  logic [WORD_SIZE-1:0]   res_d;

  assign o_busy   = (state_q != S_IDLE);
  assign o_result = o_result_q;
  assign o_valid  = o_valid_q;

  // Clamp the requested term count so the index never leaves the buffer.
  always_comb begin
    cnt_d = CW'(i_count);
    if (i_count > MEM_ADDRESS_WIDTH'(BUFFER_SIZE)) begin
      cnt_d = CW'(BUFFER_SIZE);
    end
  end

  // Ready pulses count as seen in the same cycle they arrive.
  always_comb begin
    in_flag_d = in_flag_q | i_in_ready;
    w_flag_d  = w_flag_q | i_w_ready;
    both_rdy  = in_flag_d & w_flag_d;
    last_term = (idx_q == (cnt_q - CW'(1)));
  end

  // Single shared multiplier and the accumulator update paths.
  always_comb begin
    prod = $signed(i_in_buffer[idx_q])
         * $signed(i_w_buffer[idx_q]);
    mac_d = acc_q
          + {{(AW - PW){prod[PW-1]}}, prod};
    acc_init_d =
      {{(AW - WORD_SIZE){bias_q[WORD_SIZE-1]}},
       bias_q} << FRAC_BITS;
  end

  // Round half up, saturate to the word range, then optional ReLU.
  always_comb begin
    rnd_d = {acc_q[AW-1], acc_q} + HALF_LSB;
    shr_d = rnd_d >>> FRAC_BITS;
    sat_d = shr_d[WORD_SIZE-1:0];
    if (shr_d > SAT_HI) begin
      sat_d = {1'b0, {(WORD_SIZE - 1){1'b1}}};
    end else if (shr_d < SAT_LO) begin
      sat_d = {1'b1, {(WORD_SIZE - 1){1'b0}}};
    end
    res_d = sat_d;
    if (relu_q && sat_d[WORD_SIZE-1]) begin
      res_d = '0;
    end
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      in_flag_q  <= 1'b0;
      w_flag_q   <= 1'b0;
      acc_q      <= '0;
      o_result_q <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            cnt_q     <= cnt_d;
            bias_q    <= i_bias;
            relu_q    <= i_relu;
            in_flag_q <= 1'b0;
            w_flag_q  <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          in_flag_q <= in_flag_d;
          w_flag_q  <= w_flag_d;
          if (both_rdy) begin
            acc_q <= acc_init_d;
            idx_q <= '0;
            if (cnt_q == '0) begin
              state_q <= S_RESULT;
            end else begin
              state_q <= S_MAC;
            end
          end
        end
        S_MAC: begin
          acc_q <= mac_d;
          idx_q <= idx_q + CW'(1);
          if (last_term) begin
            state_q <= S_RESULT;
          end
        end
        S_RESULT: begin
          o_result_q <= res_d;
          o_valid_q  <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_engine.sv
// tb_fc_mac_engine: directed vectors against a cycle-level reference model.
// Model computes results with plain integer math and timing from E0.
module tb_fc_mac_engine;

  localparam int BS  = 120;
  localparam int W   = 16;
  localparam int F   = 8;
  localparam int MAW = 10;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    i_start = 1'b0;
  logic [MAW-1:0]          i_count = '0;
  logic [W-1:0]            i_bias = '0;
  logic                    i_relu = 1'b0;
  logic [0:BS-1][W-1:0]    in_buf = '0;
  logic                    i_in_ready = 1'b0;
  logic [0:BS-1][W-1:0]    w_buf = '0;
  logic                    i_w_ready = 1'b0;
  logic                    o_busy;
  logic [W-1:0]            o_result;
  logic                    o_valid;

  fc_mac_engine #(
    .BUFFER_SIZE(BS),
    .WORD_SIZE(W),
    .FRAC_BITS(F),
    .MEM_ADDRESS_WIDTH(MAW),
    .GUARD_BITS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_count(i_count),
    .i_bias(i_bias),
    .i_relu(i_relu),
    .i_in_buffer(in_buf),
    .i_in_ready(i_in_ready),
    .i_w_buffer(w_buf),
    .i_w_ready(i_w_ready),
    .o_busy(o_busy),
    .o_result(o_result),
    .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  bit         m_active = 1'b0;
  int         m_s = 0;
  int         m_v = -1;
  int         m_n = 0;
  int         e0 = 0;
  logic [W-1:0] m_exp = '0;
  logic [W-1:0] m_last = '0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(int n,
                                         logic [W-1:0] b,
                                         bit relu);
    int m;
    longint acc;
    longint r;
    m = (n > BS) ? BS : n;
    acc = longint'($signed(b)) * (longint'(1) << F);
    for (int k = 0; k < m; k++) begin
      acc += longint'($signed(in_buf[k]))
           * longint'($signed(w_buf[k]));
    end
    r = (acc + (longint'(1) << (F - 1))) >>> F;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[W-1:0];
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    bit ev;
    bit eb;
    ev = m_active && m_v >= 0 && cyc == m_v;
    eb = m_active && cyc >= m_s && !(m_v >= 0 && cyc >= m_v);
    if (ev) m_last = m_exp;
    chk("busy", {31'd0, o_busy}, {31'd0, eb});
    chk("valid", {31'd0, o_valid}, {31'd0, ev});
    chk("result", {16'd0, o_result}, {16'd0, m_last});
    if (ev) m_active = 1'b0;
  end

  task automatic start_job(int n, logic [W-1:0] b, bit relu);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_count = n[MAW-1:0];
    i_bias = b;
    i_relu = relu;
    m_exp = model(n, b, relu);
    m_n = (n > BS) ? BS : n;
    m_s = cyc + 1;
    m_v = -1;
    m_active = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // gap>0: weight pulse first; gap<0: activation first; 0: together.
  task automatic pulses(int gap);
    if (gap == 0) begin
      i_in_ready = 1'b1;
      i_w_ready = 1'b1;
    end else begin
      if (gap > 0) i_w_ready = 1'b1;
      else i_in_ready = 1'b1;
      @(posedge clk);
      #1;
      i_w_ready = 1'b0;
      i_in_ready = 1'b0;
      repeat (((gap > 0) ? gap : -gap) - 1) @(posedge clk);
      #1;
      if (gap > 0) i_in_ready = 1'b1;
      else i_w_ready = 1'b1;
    end
    e0 = cyc + 1;
    m_v = e0 + m_n + 1;
    @(posedge clk);
    #1;
    i_in_ready = 1'b0;
    i_w_ready = 1'b0;
  endtask

  task automatic wait_valid(string name, int lat,
                            logic [W-1:0] exp);
    int k;
    k = 0;
    while (o_valid !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_vld"}, {31'd0, o_valid}, 32'd1);
    chk({name, "_lat"}, cyc - e0, lat);
    chk({name, "_res"}, {16'd0, o_result}, {16'd0, exp});
  endtask

  task automatic run(string name, int n, logic [W-1:0] b,
                     bit relu, int gap, int lat,
                     logic [W-1:0] exp);
    start_job(n, b, relu);
    pulses(gap);
    wait_valid(name, lat, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    in_buf[0] = 16'h0100;
    in_buf[1] = 16'h0200;
    in_buf[2] = 16'h0300;
    for (int k = 0; k < 3; k++) w_buf[k] = 16'h0100;
    chk("model_basic", {16'd0, model(3, 16'h0, 1'b0)},
        32'h0600);
    run("basic", 3, 16'h0000, 1'b0, 0, 4, 16'h0600);

    in_buf[0] = 16'h0100;
    w_buf[0] = 16'hFF00;
    chk("model_bias", {16'd0, model(1, 16'h0080, 1'b0)},
        32'hFF80);
    run("order", 1, 16'h0080, 1'b0, 5, 2, 16'hFF80);
    run("relu", 1, 16'h0080, 1'b1, -3, 2, 16'h0000);

    in_buf[0] = 16'h7F00;
    in_buf[1] = 16'h7F00;
    w_buf[0] = 16'h0200;
    w_buf[1] = 16'h0200;
    run("sat_hi", 2, 16'h0000, 1'b0, 0, 3, 16'h7FFF);
    w_buf[0] = 16'hFE00;
    w_buf[1] = 16'hFE00;
    chk("model_satlo", {16'd0, model(2, 16'h0, 1'b0)},
        32'h8000);
    run("sat_lo", 2, 16'h0000, 1'b0, 0, 3, 16'h8000);

    run("cnt0", 0, 16'h0123, 1'b0, 0, 1, 16'h0123);

    for (int k = 0; k < BS; k++) begin
      in_buf[k] = 16'h0100;
      w_buf[k] = 16'h0100;
    end
    chk("model_clamp", {16'd0, model(200, 16'h0, 1'b0)},
        32'h7800);
    run("clamp", 200, 16'h0000, 1'b0, 0, 121, 16'h7800);

    @(posedge clk);
    #1;
    i_in_ready = 1'b1;
    i_w_ready = 1'b1;
    @(posedge clk);
    #1;
    i_in_ready = 1'b0;
    i_w_ready = 1'b0;
    start_job(1, 16'h0000, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("idle_pulse_hold", {31'd0, o_busy}, 32'd1);
    pulses(0);
    wait_valid("idle_pulse", 2, 16'h0100);

    start_job(10, 16'h0000, 1'b0);
    pulses(0);
    repeat (3) @(posedge clk);
    #1;
    i_start = 1'b1;
    i_count = '0;
    i_bias = 16'h7777;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_valid("dup_start", 11, 16'h0A00);
    repeat (5) @(posedge clk);

    start_job(10, 16'h0000, 1'b0);
    pulses(0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_active = 1'b0;
    m_v = -1;
    m_last = '0;
    #1;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_result", {16'd0, o_result}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run("after_rst", 3, 16'h0000, 1'b0, 0, 4, 16'h0300);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
